// File: rtl/demux1_to_4_buf.sv
// Registered 1-to-4 demultiplexer with valid/ready on every side.
// Each destination owns a one-entry buffer and a wrapping delivery counter.
module demux1_to_4_buf #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3
);

    logic [3:0]       r_valid;
    logic [WIDTH-1:0] r_data [4];
    logic [CNT_W-1:0] r_cnt  [4];

    logic       w_accept;
    logic [3:0] w_load;
    logic [3:0] w_drain;

    // A full buffer can still accept when its destination drains this cycle.
    assign in_ready = !rst && (!r_valid[in_sel] || out_ready[in_sel]);
    assign w_accept = in_valid && in_ready;
    assign w_load   = w_accept ? (4'b0001 << in_sel) : 4'b0000;
    assign w_drain  = r_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                r_data[k] <= '0;
                r_cnt[k]  <= '0;
            end
        end else begin
            r_valid <= w_load | (r_valid & ~out_ready);
            for (int k = 0; k < 4; k++) begin
                if (w_load[k]) begin
                    r_data[k] <= in_data;
                end
                if (w_drain[k]) begin
                    r_cnt[k] <= r_cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data0 = r_data[0];
    assign out_data1 = r_data[1];
    assign out_data2 = r_data[2];
    assign out_data3 = r_data[3];
    assign cnt0      = r_cnt[0];
    assign cnt1      = r_cnt[1];
    assign cnt2      = r_cnt[2];
    assign cnt3      = r_cnt[3];

endmodule

// File: tb/tb_demux1_to_4_buf.sv
// Directed self-checking bench for demux1_to_4_buf.
// Inputs change #1 after the rising edge; outputs are sampled on the falling edge.
module tb_demux1_to_4_buf;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [1:0]  in_sel;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [15:0] out_data0;
    logic [15:0] out_data1;
    logic [15:0] out_data2;
    logic [15:0] out_data3;
    logic [7:0]  cnt0;
    logic [7:0]  cnt1;
    logic [7:0]  cnt2;
    logic [7:0]  cnt3;

    int n_assert;
    int n_fail;

    demux1_to_4_buf #(.WIDTH(16), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3),
        .cnt0      (cnt0),
        .cnt1      (cnt1),
        .cnt2      (cnt2),
        .cnt3      (cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] data_of(input int k);
        case (k)
            0: return out_data0;
            1: return out_data1;
            2: return out_data2;
            default: return out_data3;
        endcase
    endfunction

    function automatic logic [7:0] cnt_of(input int k);
        case (k)
            0: return cnt0;
            1: return cnt1;
            2: return cnt2;
            default: return cnt3;
        endcase
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 16'hFFFF;
        in_sel = 2'd0; out_ready = 4'b0000;
        #2;
        n_assert++;
        if (out_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_valid got %b want 0000", out_valid);
        end
        n_assert++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_ready got %b want 0", in_ready);
        end
        n_assert++;
        if ({cnt0, cnt1, cnt2, cnt3} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_cnt got %h want 0", {cnt0, cnt1, cnt2, cnt3});
        end
        @(posedge clk); #1;
        n_assert++;
        if (out_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_hold_valid got %b want 0000", out_valid);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic_steering();
        logic [15:0] vec [4];
        vec[0] = 16'hA001; vec[1] = 16'hB002;
        vec[2] = 16'hC003; vec[3] = 16'hD004;
        out_ready = 4'b1111;
        in_valid = 1'b1; in_data = vec[0]; in_sel = 2'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_assert++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL steer_in_ready[%0d] got %b want 1", i, in_ready);
            end
            if (i > 0) begin
                n_assert++;
                if (out_valid !== (4'b0001 << (i - 1)) ||
                    data_of(i - 1) !== vec[i - 1]) begin
                    n_fail++;
                    $display("FAIL steer_out[%0d] got v=%b d=%h want v=%b d=%h",
                             i - 1, out_valid, data_of(i - 1),
                             4'b0001 << (i - 1), vec[i - 1]);
                end
            end
            @(posedge clk); #1;
            if (i < 3) begin
                in_data = vec[i + 1];
                in_sel  = 2'(i + 1);
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        n_assert++;
        if (out_valid !== 4'b1000 || out_data3 !== 16'hD004) begin
            n_fail++;
            $display("FAIL steer_out[3] got v=%b d=%h want v=1000 d=d004",
                     out_valid, out_data3);
        end
        @(posedge clk); #1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            n_assert++;
            if (cnt_of(k) !== 8'd1) begin
                n_fail++;
                $display("FAIL steer_cnt[%0d] got %0d want 1", k, cnt_of(k));
            end
        end
    endtask

    task automatic test_stall_isolation();
        out_ready = 4'b1011;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 16'h1111; in_sel = 2'd2;
        @(negedge clk);
        n_assert++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_first_ready got %b want 1", in_ready);
        end
        @(posedge clk); #1;
        in_data = 16'h2222; in_sel = 2'd2;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_assert++;
            if (in_ready !== 1'b0 || out_data2 !== 16'h1111 ||
                out_valid[2] !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold[%0d] got rdy=%b d2=%h v2=%b want 0 1111 1",
                         c, in_ready, out_data2, out_valid[2]);
            end
            @(posedge clk); #1;
        end
        in_data = 16'h3333; in_sel = 2'd0;
        @(negedge clk);
        n_assert++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_other_ready got %b want 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_assert++;
        if (out_valid !== 4'b0101 || out_data0 !== 16'h3333 ||
            out_data2 !== 16'h1111) begin
            n_fail++;
            $display("FAIL stall_other_out got v=%b d0=%h d2=%h want 0101 3333 1111",
                     out_valid, out_data0, out_data2);
        end
        @(posedge clk); #1;
        out_ready = 4'b1111;
        @(posedge clk); #1;
        @(negedge clk);
        n_assert++;
        if (out_valid !== 4'b0000 || cnt0 !== 8'd2 || cnt2 !== 8'd2 ||
            cnt1 !== 8'd1 || cnt3 !== 8'd1) begin
            n_fail++;
            $display("FAIL stall_cnt got v=%b c=%0d/%0d/%0d/%0d want 0000 2/1/2/1",
                     out_valid, cnt0, cnt1, cnt2, cnt3);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 4'b1111;
        in_valid = 1'b1; in_sel = 2'd1; in_data = 16'h0000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_assert++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready[%0d] got %b want 1", i, in_ready);
            end
            if (i > 0) begin
                n_assert++;
                if (out_valid[1] !== 1'b1 || out_data1 !== 16'(i - 1)) begin
                    n_fail++;
                    $display("FAIL b2b_out[%0d] got v=%b d=%h want 1 %h",
                             i - 1, out_valid[1], out_data1, 16'(i - 1));
                end
            end
            @(posedge clk); #1;
            if (i < 9) in_data = 16'(i + 1);
            else in_valid = 1'b0;
        end
        @(negedge clk);
        n_assert++;
        if (out_valid[1] !== 1'b1 || out_data1 !== 16'h0009) begin
            n_fail++;
            $display("FAIL b2b_out[9] got v=%b d=%h want 1 0009",
                     out_valid[1], out_data1);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_assert++;
        if (cnt1 !== 8'd10 || out_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL b2b_cnt got c=%0d v=%b want 10 0000", cnt1, out_valid);
        end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        out_ready = 4'b1111;
        in_valid = 1'b1; in_sel = 2'd3;
        for (int i = 0; i < 255; i++) begin
            in_data = 16'(i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_assert++;
        if (cnt3 !== 8'hFF) begin
            n_fail++;
            $display("FAIL wrap_255 got %h want ff", cnt3);
        end
        in_valid = 1'b1; in_data = 16'h00FF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_assert++;
        if (cnt3 !== 8'h00) begin
            n_fail++;
            $display("FAIL wrap_256 got %h want 00", cnt3);
        end
        n_assert++;
        if ({cnt0, cnt1, cnt2} !== 24'h0) begin
            n_fail++;
            $display("FAIL wrap_others got %h want 0", {cnt0, cnt1, cnt2});
        end
    endtask

    task automatic test_async_reset();
        out_ready = 4'b0001;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 16'h0A0A; in_sel = 2'd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 4'b0000;
        in_valid = 1'b1; in_data = 16'hAAAA; in_sel = 2'd0;
        @(posedge clk); #1;
        in_data = 16'h5555; in_sel = 2'd2;
        @(posedge clk); #1;
        in_sel = 2'd1; in_data = 16'h7777;
        @(negedge clk);
        n_assert++;
        if (out_valid !== 4'b0101 || cnt0 !== 8'd1 || out_data0 !== 16'hAAAA) begin
            n_fail++;
            $display("FAIL arst_setup got v=%b c0=%0d d0=%h want 0101 1 aaaa",
                     out_valid, cnt0, out_data0);
        end
        #1 rst = 1'b1;
        #1;
        n_assert++;
        if (out_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL arst_valid got %b want 0000", out_valid);
        end
        n_assert++;
        if ({out_data0, out_data1, out_data2, out_data3} !== 64'h0 ||
            {cnt0, cnt1, cnt2, cnt3} !== 32'h0) begin
            n_fail++;
            $display("FAIL arst_clear got d=%h c=%h want 0 0",
                     {out_data0, out_data1, out_data2, out_data3},
                     {cnt0, cnt1, cnt2, cnt3});
        end
        n_assert++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_in_ready got %b want 0", in_ready);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset_midop();
        out_ready = 4'b0010;
        in_valid = 1'b1; in_data = 16'h0BAD; in_sel = 2'd1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 4'b0000;
        in_valid = 1'b1; in_data = 16'hBEEF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_assert++;
        if (out_valid[1] !== 1'b1 || out_data1 !== 16'hBEEF || cnt1 !== 8'd1) begin
            n_fail++;
            $display("FAIL midop_setup got v=%b d=%h c=%0d want 1 beef 1",
                     out_valid[1], out_data1, cnt1);
        end
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        n_assert++;
        if (out_valid[1] !== 1'b0 || cnt1 !== 8'd0 || out_data1 !== 16'h0) begin
            n_fail++;
            $display("FAIL midop_discard got v=%b c=%0d d=%h want 0 0 0000",
                     out_valid[1], cnt1, out_data1);
        end
        @(posedge clk); #1;
        out_ready = 4'b0010;
        in_valid = 1'b1; in_data = 16'h1234; in_sel = 2'd1;
        @(negedge clk);
        n_assert++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_ready got %b want 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_assert++;
        if (out_valid !== 4'b0010 || out_data1 !== 16'h1234) begin
            n_fail++;
            $display("FAIL midop_deliver got v=%b d=%h want 0010 1234",
                     out_valid, out_data1);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_assert++;
        if (cnt1 !== 8'd1 || out_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL midop_cnt got c=%0d v=%b want 1 0000", cnt1, out_valid);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        in_valid = 1'b0; in_data = '0; in_sel = '0;
        out_ready = '0; rst = 1'b1;
        test_reset();
        test_basic_steering();
        test_stall_isolation();
        test_back_to_back();
        test_counter_wrap();
        test_async_reset();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/demux1_to_4_buf.md
Name: demux1_to_4_buf

Overview:
- Registered 1-to-4 demultiplexer with valid/ready handshake on every side; the distribution counterpart of the 16-bit 4-to-1 operand/result selection muxes.
- One source word is steered to one of four destinations (e.g. ALU result to register write port, memory data path, PC load, or I/O) by a 2-bit select.
- Each destination has a one-entry output register, so a stalled destination blocks only traffic addressed to it.
- Per-destination delivery counters support debug and performance monitoring.

Parameters:
- WIDTH, 16, data word width.
- CNT_W, 8, width of each per-channel delivery counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  source has a word.
- in_ready  output  1  block accepts the word this cycle.
- in_data  input  WIDTH  source word.
- in_sel  input  2  destination index, 0..3.
- out_valid  output  4  bit k: channel k holds a word.
- out_ready  input  4  bit k: destination k consumes this cycle.
- out_data0  output  WIDTH  channel 0 word.
- out_data1  output  WIDTH  channel 1 word.
- out_data2  output  WIDTH  channel 2 word.
- out_data3  output  WIDTH  channel 3 word.
- cnt0  output  CNT_W  deliveries completed on channel 0.
- cnt1  output  CNT_W  deliveries completed on channel 1.
- cnt2  output  CNT_W  deliveries completed on channel 2.
- cnt3  output  CNT_W  deliveries completed on channel 3.

Behaviour:
- Reset, asynchronous: out_valid=4'b0000, out_data0..3=0, cnt0..3=0. in_ready is forced 0 while rst=1. Buffered words are discarded when reset asserts mid-transfer.
- Input acceptance: in_ready = !rst && (!out_valid[in_sel] || out_ready[in_sel]). This is combinational from in_sel, out_valid and out_ready.
- Accept event: in_valid && in_ready at a rising edge.
- Source protocol rule: in_data and in_sel are held stable while in_valid=1 and in_ready=0. in_valid is not withdrawn before acceptance.
- Latency: on an accept, out_data[in_sel] is loaded with in_data and out_valid[in_sel] is set, both visible the cycle after acceptance. There is no combinational path from in_data to out_data.
- Drain event, channel k: out_valid[k] && out_ready[k] at a rising edge. On drain, out_valid[k] clears and cnt[k] increments.
- Simultaneous drain and accept on the same channel k: out_valid[k] stays 1, out_data[k] takes the new word, cnt[k] increments. This gives full throughput of one word per cycle per channel.
- Channel k stalled (out_valid[k]=1, out_ready[k]=0): out_data[k] is held stable. Accepts to other channels proceed normally.
- out_data[k] retains its last value after a drain. It is only meaningful while out_valid[k]=1.
- At most one accept per cycle. Any number of channels may drain in the same cycle.
- out_ready[k] while out_valid[k]=0 is ignored: no counter change, no state change.
- in_valid=0: no state change other than drains.
- Counters are unsigned and wrap modulo 2^CNT_W (255 then 0 at the default width). They are not saturating.
- The block has no internal FSM beyond per-channel full/empty. Channel state: EMPTY moves to FULL on accept. FULL moves to EMPTY on drain without accept. FULL stays FULL on drain with accept.

Test Plan:
- Reset check: assert rst mid-simulation with out_valid=4'b0101. Required: out_valid=0, out_data0..3=0 and cnt0..3=0 immediately, with no clock edge needed, and in_ready=0 while rst=1.
- Basic steering: out_ready=4'b1111; send 16'hA001 sel=0, 16'hB002 sel=1, 16'hC003 sel=2, 16'hD004 sel=3 on consecutive cycles. Required: each word appears on its out_dataN with out_valid[N]=1 exactly one cycle after its accept. Afterwards cnt0..3=1 and in_ready stays 1 throughout.
- Stall isolation: out_ready[2]=0; send 16'h1111 sel=2, then 16'h2222 sel=2, then 16'h3333 sel=0. Required: out_data2 holds 16'h1111 and in_ready=0 while sel=2 is presented. After the source switches to 16'h3333 sel=0, in_ready=1 and out_data0=16'h3333 one cycle later.
- Full throughput on one channel: out_ready[1]=1; send 16'h0000..16'h0009 back-to-back with sel=1. Required: one word per cycle on out_data1 in order, out_valid[1] continuously 1 for 10 cycles, cnt1=10.
- Counter wrap: 256 deliveries on channel 3. Required: cnt3 reads 8'hFF after the 255th delivery and 8'h00 after the 256th; the other counters are unchanged.
- Reset mid-operation: channel 1 full with 16'hBEEF and out_ready=0; pulse rst. Required: out_valid[1]=0, the word is discarded, cnt1=0, and the next accept sel=1 of 16'h1234 delivers normally.
